// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers.
// One multiply or divide step is performed per cycle, so an operation takes XLEN cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request a new operation (accepted in IDLE or DONE only)
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b       multiplicand/dividend and multiplier/divisor
//   flush      aborts any operation in progress; HI/LO are kept
//   busy       high while iterating
//   done       one-cycle pulse when HI/LO have just been written
//   hi, lo     product upper/lower half, or remainder/quotient
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = 2 * XLEN;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   cnt;
  logic            accept, lastStep;

  // Operand/iteration registers (data only, never reset)
  logic            isDiv, negMain, negRem, divZero;
  logic [XLEN-1:0] bMag, aRaw, accHi, accLo;

  logic [XLEN-1:0] stepHi, stepLo, finHi, finLo;
  logic [XLEN:0]   mulSum, remShift;
  logic [XLEN-1:0] remSub;
  logic            remGeq;
  logic [PW-1:0]   prodFinal;

  function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [PW-1:0] condNegWide(input logic [PW-1:0] x, input logic neg);
    return neg ? (~x + PW'(1)) : x;
  endfunction

  assign accept   = start && !flush && (state != RUN);
  assign lastStep = (state == RUN) && (cnt == LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // One radix-2 step: multiply keeps {accHi, accLo} as a right-shifting
  // accumulator/multiplier pair; divide keeps remainder in accHi and shifts
  // the dividend out of accLo while quotient bits shift in.
  assign mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? bMag : '0)};
  assign remShift = {accHi, accLo[XLEN-1]};
  assign remGeq   = (remShift >= {1'b0, bMag});
  // The difference is always below bMag when taken, so XLEN bits suffice.
  assign remSub   = remShift[XLEN-1:0] - bMag;

  always_comb begin
    stepHi = accHi;
    stepLo = accLo;
    if (isDiv) begin
      stepHi = remGeq ? remSub : remShift[XLEN-1:0];
      stepLo = {accLo[XLEN-2:0], remGeq};
    end else begin
      stepHi = mulSum[XLEN:1];
      stepLo = {mulSum[0], accLo[XLEN-1:1]};
    end
  end

  // Sign correction of the final step result
  assign prodFinal = condNegWide({stepHi, stepLo}, negMain);

  always_comb begin
    finHi = prodFinal[PW-1:XLEN];
    finLo = prodFinal[XLEN-1:0];
    if (isDiv) begin
      if (divZero) begin
        finHi = aRaw;
        finLo = '1;
      end else begin
        finHi = condNeg(stepHi, negRem);
        finLo = condNeg(stepLo, negMain);
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) stateNext = RUN;
        RUN:     if (lastStep) stateNext = DONE;
        DONE:    stateNext = start ? RUN : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Control and architectural result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      if (lastStep && !flush) begin
        hi <= finHi;
        lo <= finLo;
      end
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      isDiv   <= op[1];
      negMain <= op[0] & (a[XLEN-1] ^ b[XLEN-1]);
      negRem  <= op[0] & a[XLEN-1];
      divZero <= (b == '0);
      aRaw    <= a;
      accHi   <= '0;
      accLo   <= condNeg(a, op[0] & a[XLEN-1]);
      bMag    <= condNeg(b, op[0] & b[XLEN-1]);
    end else if (state == RUN) begin
      accHi <= stepHi;
      accLo <= stepLo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on 64-bit values, result as {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, m;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    r = '0;
    case (o)
      2'd0: r = {32'h0, x} * {32'h0, y};
      2'd1: r = sx * sy;
      2'd2: if (y == 0) r = {x, 32'hFFFF_FFFF}; else r = {x % y, x / y};
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after the start edge; stops at done or budget.
  task automatic waitDone(output int busyCnt, output int cyc);
    busyCnt = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int bc, cy;
    logic [63:0] exp;
    exp = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    waitDone(bc, cy);
    check({tag, "_latency"}, 64'(cy), 64'd32);
    check({tag, "_busycnt"}, 64'(bc), 64'd32);
    check({tag, "_result"}, {hi, lo}, exp);
    @(negedge clk);
    check({tag, "_pulse"}, {62'h0, busy, done}, 64'h0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc, cy, doneSeen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
    #12;
    check("reset_state", {30'h0, busy, done, hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ff");
    check("multu_ff_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    runOp(2'd1, -32'd3, 32'd5, "mult_m3x5");
    check("mult_m3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(2'd3, -32'd7, 32'd2, "div_m7d2");
    check("div_m7d2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(2'd2, 32'd100, 32'd0, "divu_by0");
    check("divu_by0_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    runOp(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    runOp(2'd3, -32'd9, 32'd0, "div_by0");

    // Start while running is ignored
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd17; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    waitDone(bc, cy);
    check("ignore_latency", 64'(cy), 64'd27);
    check("ignore_result", {hi, lo}, {32'd2, 32'd3});
    @(negedge clk);
    check("ignore_idle_after", {62'h0, busy, done}, 64'h0);

    // Flush mid-operation keeps the previous result
    runOp(2'd2, 32'd5, 32'd2, "divu_5d2");
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_done", {62'h0, busy, done}, 64'h0);
    check("flush_hilo", {hi, lo}, {32'd1, 32'd2});
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    check("flush_no_done", 64'(doneSeen), 64'd0);
    check("flush_hilo_late", {hi, lo}, {32'd1, 32'd2});

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = -32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {30'h0, busy, done, hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    runOp(2'd0, 32'd6, 32'd7, "multu_6x7");
    check("multu_6x7_const", {hi, lo}, 64'd42);

    // Randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      runOp(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and HI/LO width; iteration count equals XLEN.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising clk.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 SHALL have port a  input  XLEN  multiplicand or dividend (rs).
REQ-007 SHALL have port b  input  XLEN  multiplier or divisor (rt).
REQ-008 SHALL have port flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port busy  output  1  high while an operation is iterating; drives pipeline stall.
REQ-010 SHALL have port done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-011 SHALL have port hi  output  XLEN  HI register (product upper half or remainder).
REQ-012 SHALL have port lo  output  XLEN  LO register (product lower half or quotient).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; at that edge latch op, |a|, |b| (magnitudes for signed ops), result signs, clear the iteration counter, and enter RUN.
REQ-015 SHALL ignore start while in RUN; the in-flight operation and its operands are unaffected.
REQ-016 SHALL perform exactly one radix-2 step per cycle in RUN: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 SHALL, on the XLEN-th RUN edge, apply sign correction, write hi/lo, and enter DONE.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, XLEN cycles after the edge that sampled start.
REQ-019 SHALL assert busy in RUN only; busy is low in IDLE and DONE.
REQ-020 SHALL transition DONE -> IDLE on the next edge unless start is sampled, then DONE -> RUN.
REQ-021 SHALL, for MULT/MULTU, produce the full 2*XLEN-bit product as {hi,lo}, two's-complement for MULT.
REQ-022 SHALL, for DIV, truncate toward zero: quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-023 SHALL, on divide by zero (either DIV or DIVU), set hi = a, lo = all ones, no exception, same latency.
REQ-024 SHALL, for DIV with a = most negative value and b = -1, set lo = most negative value, hi = 0.
REQ-025 SHALL hold hi/lo unchanged at all times except the REQ-017 write.
REQ-026 SHALL, when flush is high at an edge, enter IDLE, drop busy and done, discard partial results, and leave hi/lo unchanged; flush overrides a simultaneous start.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse; first start after release behaves per REQ-014.

Verification
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 32 cycles; done pulse once; hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF after 32 cycles; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-032 DIVU 17/5 started, start with new operands pulsed at cycle 5 -> ignored; hi=2, lo=3.
REQ-033 Prior result hi=1, lo=2; new MULTU started, flush at cycle 10 -> next cycle busy=0, no done, hi=1, lo=2.
REQ-034 rst pulsed asynchronously (mid-cycle) at cycle 20 of a DIV -> busy, done, hi, lo read 0 immediately; a new MULTU 6*7 after release gives lo=42, hi=0.
